// File: rtl/sar_capture_pkg.sv
// rtl/sar_capture_pkg.sv - shared types and helpers for the SAR result capture block
package sar_capture_pkg;

    localparam int RESULT_W_DEF = 11;

    typedef enum logic {
        WAIT_HIGH = 1'b0,
        WAIT_LOW  = 1'b1
    } cap_state_t;

    // Offset binary to two's complement is a flip of the sign bit.
    function automatic logic [RESULT_W_DEF-1:0] fmt_sample(
        input logic [RESULT_W_DEF-1:0] value,
        input logic                    twos
    );
        logic [RESULT_W_DEF-1:0] out;
        out                 = value;
        out[RESULT_W_DEF-1] = value[RESULT_W_DEF-1] ^ twos;
        return out;
    endfunction

endpackage

// File: rtl/sar_sync_fifo.sv
// rtl/sar_sync_fifo.sv - single-clock FIFO with registered head-of-queue output
module sar_sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_next;
    logic [AW:0]      rd_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign wr_next = wr_ptr + {{AW{1'b0}}, do_push};
    assign rd_next = rd_ptr + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // The head register must already show the word written at this edge when
    // the queue was (or became) empty, so bypass the array in that case.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            if (wr_next != rd_next) begin
                if (do_push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
                    head <= push_data;
                end else begin
                    head <= mem[rd_next[AW-1:0]];
                end
            end
        end
    end

endmodule

// File: rtl/sar_result_capture.sv
// rtl/sar_result_capture.sv - captures SAR conversion words, averages, formats and buffers them
module sar_result_capture
    import sar_capture_pkg::*;
#(
    parameter int RESULT_W   = RESULT_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int AVG_LOG2   = 0,
    parameter int TWOS_COMP  = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                conv_done,
    input  logic [RESULT_W-1:0] result,
    output logic [RESULT_W-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                overflow,
    input  logic                clear_ovf,
    output logic [15:0]         sample_count
);

    localparam int ACC_W = RESULT_W + AVG_LOG2;
    localparam int GRP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'((1 << AVG_LOG2) - 1);
    localparam logic TWOS = (TWOS_COMP != 0);

    logic             sync1, sync2, sync3;
    logic [1:0]       sync_fill;
    logic             armed;
    logic             evt;
    logic             fire;
    cap_state_t       state, state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [GRP_W-1:0] grp;
    logic             grp_done;
    logic [RESULT_W-1:0] avg;
    logic [RESULT_W-1:0] push_data;
    logic             push;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;

    // sync_fill marks when sync2 truly reflects conv_done, so a strobe already
    // high at reset release cannot arm the edge detector from reset values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sync1     <= conv_done;
            sync2     <= sync1;
            sync3     <= sync2;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && !sync2) begin
                armed <= 1'b1;
            end
        end
    end

    assign evt = sync2 && !sync3 && armed && enable;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= WAIT_HIGH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fire       = 1'b0;
        if (!enable) begin
            state_next = WAIT_HIGH;
        end else begin
            case (state)
                WAIT_HIGH: begin
                    if (evt) begin
                        fire       = 1'b1;
                        state_next = WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!sync2) begin
                        state_next = WAIT_HIGH;
                    end
                end
                default: state_next = WAIT_HIGH;
            endcase
        end
    end

    assign sum      = acc + ACC_W'(result);
    assign grp_done = (grp == GRP_LAST);
    assign avg      = sum[ACC_W-1:AVG_LOG2];
    assign push     = fire && grp_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
            grp <= '0;
        end else if (!enable) begin
            acc <= '0;
            grp <= '0;
        end else if (fire) begin
            if (grp_done) begin
                acc <= '0;
                grp <= '0;
            end else begin
                acc <= sum;
                grp <= grp + 1'b1;
            end
        end
    end

    if (RESULT_W == RESULT_W_DEF) begin : g_fmt_pkg
        assign push_data = fmt_sample(avg, TWOS);
    end else begin : g_fmt_gen
        assign push_data = {avg[RESULT_W-1] ^ TWOS, avg[RESULT_W-2:0]};
    end

    sar_sync_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (m_data)
    );

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    assign drop    = push && fifo_full && !pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow     <= 1'b0;
            sample_count <= 16'd0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
            if (push && !drop) begin
                sample_count <= sample_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sar_result_capture.sv
// tb/tb_sar_result_capture.sv - directed self-checking bench for sar_result_capture
module tb_sar_result_capture;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        conv_done = 1'b0;
    logic [10:0] result = '0;
    logic        m_ready = 1'b0;
    logic        clear_ovf = 1'b0;

    logic [10:0] d0_data, d2_data;
    logic        d0_valid, d2_valid;
    logic        d0_ovf, d2_ovf;
    logic [15:0] d0_cnt, d2_cnt;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    sar_result_capture #(.RESULT_W(11), .FIFO_DEPTH(4), .AVG_LOG2(0), .TWOS_COMP(1)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .conv_done(conv_done),
        .result(result), .m_data(d0_data), .m_valid(d0_valid), .m_ready(m_ready),
        .overflow(d0_ovf), .clear_ovf(clear_ovf), .sample_count(d0_cnt)
    );

    sar_result_capture #(.RESULT_W(11), .FIFO_DEPTH(4), .AVG_LOG2(2), .TWOS_COMP(0)) dut2 (
        .clock(clock), .reset(reset), .enable(enable), .conv_done(conv_done),
        .result(result), .m_data(d2_data), .m_valid(d2_valid), .m_ready(m_ready),
        .overflow(d2_ovf), .clear_ovf(clear_ovf), .sample_count(d2_cnt)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        conv_done = 1'b0;
        clear_ovf = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic conv(input logic [10:0] v);
        result = v;
        conv_done = 1'b1;
        repeat (4) tick();
        conv_done = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        total++; if (d0_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", d0_valid); end
        total++; if (d0_data !== 11'h000) begin bad++; $display("FAIL reset_data got=%h exp=000", d0_data); end
        total++; if (d0_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", d0_ovf); end
        total++; if (d0_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", d0_cnt); end
        total++; if (d2_valid !== 1'b0) begin bad++; $display("FAIL reset_valid2 got=%b exp=0", d2_valid); end
        do_reset();
    endtask

    task automatic test_latency;
        do_reset();
        m_ready = 1'b1;
        result = 11'h400;
        conv_done = 1'b1;
        tick();
        tick();
        total++; if (d0_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", d0_valid); end
        tick();
        total++; if (d0_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b exp=1", d0_valid); end
        total++; if (d0_data !== 11'h000) begin bad++; $display("FAIL lat_data got=%h exp=000", d0_data); end
        total++; if (d0_cnt !== 16'd1) begin bad++; $display("FAIL lat_cnt got=%0d exp=1", d0_cnt); end
        tick();
        conv_done = 1'b0;
        repeat (4) tick();
        total++; if (d0_valid !== 1'b0) begin bad++; $display("FAIL lat_drained got=%b exp=0", d0_valid); end
        total++; if (d0_cnt !== 16'd1) begin bad++; $display("FAIL lat_cnt_once got=%0d exp=1", d0_cnt); end
        total++; if (d2_cnt !== 16'd0) begin bad++; $display("FAIL lat_avg_nopush got=%0d exp=0", d2_cnt); end
    endtask

    task automatic test_average;
        do_reset();
        m_ready = 1'b0;
        conv(11'd100);
        conv(11'd101);
        conv(11'd102);
        total++; if (d2_cnt !== 16'd0) begin bad++; $display("FAIL avg_early_cnt got=%0d exp=0", d2_cnt); end
        total++; if (d2_valid !== 1'b0) begin bad++; $display("FAIL avg_early_valid got=%b exp=0", d2_valid); end
        conv(11'd104);
        total++; if (d2_cnt !== 16'd1) begin bad++; $display("FAIL avg_cnt got=%0d exp=1", d2_cnt); end
        total++; if (d2_data !== 11'd101) begin bad++; $display("FAIL avg_data got=%0d exp=101", d2_data); end
        total++; if (d0_data !== 11'h464) begin bad++; $display("FAIL avg_twos_head got=%h exp=464", d0_data); end
        total++; if (d0_cnt !== 16'd4) begin bad++; $display("FAIL avg_d0_cnt got=%0d exp=4", d0_cnt); end
        total++; if (d0_ovf !== 1'b0) begin bad++; $display("FAIL avg_d0_ovf got=%b exp=0", d0_ovf); end
    endtask

    task automatic test_overflow;
        do_reset();
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) conv(11'(i));
        total++; if (d0_cnt !== 16'd4) begin bad++; $display("FAIL ovf_cnt got=%0d exp=4", d0_cnt); end
        total++; if (d0_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", d0_ovf); end
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        total++; if (d0_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", d0_ovf); end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (d0_valid !== 1'b1 || d0_data !== (11'h400 | 11'(i + 1))) begin
                bad++;
                $display("FAIL ovf_drain[%0d] got=%b/%h exp=1/%h", i, d0_valid, d0_data, 11'h400 | 11'(i + 1));
            end
            tick();
        end
        total++; if (d0_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", d0_valid); end
    endtask

    task automatic test_reset_high;
        reset = 1'b1;
        m_ready = 1'b0;
        enable = 1'b1;
        result = 11'h123;
        conv_done = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (6) tick();
        total++; if (d0_cnt !== 16'd0) begin bad++; $display("FAIL rsthigh_cnt got=%0d exp=0", d0_cnt); end
        total++; if (d0_valid !== 1'b0) begin bad++; $display("FAIL rsthigh_valid got=%b exp=0", d0_valid); end
        conv_done = 1'b0;
        repeat (4) tick();
        conv(11'h123);
        total++; if (d0_cnt !== 16'd1) begin bad++; $display("FAIL rsthigh_one got=%0d exp=1", d0_cnt); end
        total++; if (d0_data !== 11'h523) begin bad++; $display("FAIL rsthigh_data got=%h exp=523", d0_data); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) conv(11'h010 + 11'(i));
        result = 11'h015;
        conv_done = 1'b1;
        tick();
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        total++; if (d0_ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%b exp=0", d0_ovf); end
        total++; if (d0_cnt !== 16'd5) begin bad++; $display("FAIL b2b_cnt got=%0d exp=5", d0_cnt); end
        tick();
        conv_done = 1'b0;
        repeat (4) tick();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (d0_valid !== 1'b1 || d0_data !== (11'h412 + 11'(i))) begin
                bad++;
                $display("FAIL b2b_drain[%0d] got=%b/%h exp=1/%h", i, d0_valid, d0_data, 11'h412 + 11'(i));
            end
            tick();
        end
        total++; if (d0_valid !== 1'b0) begin bad++; $display("FAIL b2b_occupancy got=%b exp=0", d0_valid); end
    endtask

    task automatic test_enable;
        do_reset();
        m_ready = 1'b0;
        conv(11'd8);
        conv(11'd8);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) conv(11'd8);
        total++; if (d0_cnt !== 16'd2) begin bad++; $display("FAIL en_off_cnt got=%0d exp=2", d0_cnt); end
        enable = 1'b1;
        conv(11'd8);
        conv(11'd8);
        total++; if (d2_cnt !== 16'd0) begin bad++; $display("FAIL en_acc_cleared got=%0d exp=0", d2_cnt); end
        conv(11'd8);
        conv(11'd8);
        total++; if (d2_cnt !== 16'd1) begin bad++; $display("FAIL en_avg_cnt got=%0d exp=1", d2_cnt); end
        total++; if (d2_data !== 11'd8) begin bad++; $display("FAIL en_avg_data got=%0d exp=8", d2_data); end
    endtask

    task automatic test_stuck;
        do_reset();
        m_ready = 1'b1;
        result = 11'h010;
        conv_done = 1'b1;
        repeat (20) tick();
        total++; if (d0_cnt !== 16'd1) begin bad++; $display("FAIL stuck_cnt got=%0d exp=1", d0_cnt); end
        conv_done = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_average();
        test_overflow();
        test_reset_high();
        test_back_to_back();
        test_enable();
        test_stuck();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
